activation_pipeline: RTL and testbench

- Multi-lane, pipelined piecewise-linear activation unit: fx = a[seg]*x + b[seg] per lane, saturated to Q_INT.Q_FRAC.
- Next-generation activation stage between accumulator output and layer writeback.
- Adds over the previous generation: LANES parallel lanes, valid/ready stall handshake, sign-correct bias alignment, output saturation, and a registered 3-stage pipeline.
- Per-lane coefficient LUTs, all written identically, are selected by a function mask.

---
 rtl/activation_pipeline_pkg.sv | 44 ++++
 rtl/activation_pipeline_pwl.sv | 97 +++++++++
 rtl/activation_pipeline.sv | 65 ++++++
 tb/tb_activation_pipeline.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/activation_pipeline_pkg.sv
// Shared fixed-point formats, coefficient word layout and output saturation
// for the piecewise-linear activation pipeline.
package activation_pipeline_pkg;

    localparam int unsigned Q_INT    = 8;
    localparam int unsigned Q_FRAC   = 8;
    localparam int unsigned A_Q_INT  = 4;
    localparam int unsigned A_Q_FRAC = 8;
    localparam int unsigned B_Q_INT  = 8;
    localparam int unsigned B_Q_FRAC = 8;

    localparam int unsigned X_W     = Q_INT + Q_FRAC;
    localparam int unsigned A_W     = A_Q_INT + A_Q_FRAC;
    localparam int unsigned B_W     = B_Q_INT + B_Q_FRAC;
    localparam int unsigned C_W     = A_W + B_W;
    // Product a*x is Q(Q_INT+A_Q_INT).(Q_FRAC+A_Q_FRAC)
    localparam int unsigned P_W     = X_W + A_W;
    localparam int unsigned P_FRAC  = Q_FRAC + A_Q_FRAC;
    // Sum carries one guard bit above the product
    localparam int unsigned S_W     = P_W + 1;
    localparam int unsigned B_SHIFT = P_FRAC - B_Q_FRAC;
    // Sum after dropping the low A_Q_FRAC fraction bits
    localparam int unsigned T_W     = S_W - A_Q_FRAC;

    // Coefficient word: slope in the MSBs, bias in the LSBs
    typedef struct packed {
        logic signed [A_W-1:0] a;
        logic signed [B_W-1:0] b;
    } coef_t;

    // Clamp a Q(T_W-Q_FRAC).Q_FRAC value into the signed X_W-bit range
    function automatic logic [X_W-1:0] saturate(input logic [T_W-1:0] t);
        logic [T_W-X_W:0] head;
        head = t[T_W-1:X_W-1];
        if (head == '0 || head == '1) begin
            return t[X_W-1:0];
        end else if (t[T_W-1]) begin
            return {1'b1, {(X_W-1){1'b0}}};
        end else begin
            return {1'b0, {(X_W-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/activation_pipeline_pwl.sv
// One activation lane: coefficient LUT with synchronous read-first access,
// product stage, and bias-align / floor / saturate output stage.
module pwl_lane
    import activation_pipeline_pkg::*;
#(
    parameter int unsigned MASK_SIZE = 2,
    parameter int unsigned LUT_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cfg_we,
    input  logic [MASK_SIZE-1:0] cfg_mask,
    input  logic [LUT_DEPTH-1:0] cfg_addr,
    input  logic [C_W-1:0]       cfg_data,
    input  logic [X_W-1:0]       x,
    input  logic [MASK_SIZE-1:0] mask,
    input  logic                 bypass,
    output logic [X_W-1:0]       fx
);

    localparam int unsigned ADDR_W = MASK_SIZE + LUT_DEPTH;

    logic [C_W-1:0]        mem [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0]     rd_addr;
    logic [ADDR_W-1:0]     wr_addr;

    coef_t                 coef1;
    logic [X_W-1:0]        x1;
    logic                  byp1;

    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] x_ext;
    logic signed [P_W-1:0] prod;

    logic signed [P_W-1:0] p2;
    logic [B_W-1:0]        b2;
    logic [X_W-1:0]        x2;
    logic                  byp2;

    logic signed [S_W-1:0] b_al;
    logic signed [S_W-1:0] sum;
    logic [X_W-1:0]        fx_d;

    assign rd_addr = {mask, x[X_W-1 -: LUT_DEPTH]};
    assign wr_addr = {cfg_mask, cfg_addr};

    // LUT write port: independent of the stall, lands on any edge
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            mem[wr_addr] <= cfg_data;
        end
    end

    // S1: LUT read data and operand capture; read sees pre-write contents
    always_ff @(posedge clk) begin
        if (en) begin
            coef1 <= mem[rd_addr];
            x1    <= x;
            byp1  <= bypass;
        end
    end

    // S2 datapath: full signed product a*x
    always_comb begin
        a_ext = {{(P_W-A_W){coef1.a[A_W-1]}}, coef1.a};
        x_ext = {{(P_W-X_W){x1[X_W-1]}}, x1};
        prod  = a_ext * x_ext;
    end

    // S2 register: product, bias, operand and bypass flag
    always_ff @(posedge clk) begin
        if (en) begin
            p2   <= prod;
            b2   <= coef1.b;
            x2   <= x1;
            byp2 <= byp1;
        end
    end

    // S3 datapath: align bias to the product format, add, floor, saturate
    always_comb begin
        b_al = {{(S_W-B_W-B_SHIFT){b2[B_W-1]}}, b2, {B_SHIFT{1'b0}}};
        sum  = {p2[P_W-1], p2} + b_al;
        fx_d = byp2 ? x2 : saturate(T_W'(sum >>> A_Q_FRAC));
    end

    // S3 register: lane result, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fx <= '0;
        end else if (en) begin
            fx <= fx_d;
        end
    end

endmodule

// File: rtl/activation_pipeline.sv
// Multi-lane piecewise-linear activation unit: valid pipeline, global
// stall enable and lane packing around LANES pwl_lane instances.
module activation_pipeline
    import activation_pipeline_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned LUT_DEPTH = 4,
    parameter int unsigned MASK_SIZE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*X_W-1:0]   in_data,
    input  logic [MASK_SIZE-1:0]   in_mask,
    input  logic                   in_bypass,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*X_W-1:0]   out_data,
    input  logic                   cfg_we,
    input  logic [MASK_SIZE-1:0]   cfg_mask,
    input  logic [LUT_DEPTH-1:0]   cfg_addr,
    input  logic [C_W-1:0]         cfg_data
);

    logic en;
    logic v1;
    logic v2;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Stage valid pipeline; bubbles travel as invalid stages
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pwl_lane #(
            .MASK_SIZE (MASK_SIZE),
            .LUT_DEPTH (LUT_DEPTH)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .cfg_we   (cfg_we),
            .cfg_mask (cfg_mask),
            .cfg_addr (cfg_addr),
            .cfg_data (cfg_data),
            .x        (in_data[i*X_W +: X_W]),
            .mask     (in_mask),
            .bypass   (in_bypass),
            .fx       (out_data[i*X_W +: X_W])
        );
    end

endmodule

// File: tb/tb_activation_pipeline.sv
// Directed bench for activation_pipeline with hand-computed expectations.
module tb_activation_pipeline;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_mask;
    logic        in_bypass;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        cfg_we;
    logic [1:0]  cfg_mask;
    logic [3:0]  cfg_addr;
    logic [27:0] cfg_data;

    int total = 0;
    int bad   = 0;

    activation_pipeline #(
        .LANES     (4),
        .LUT_DEPTH (4),
        .MASK_SIZE (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_mask  (cfg_mask),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] m, input logic [3:0] a, input logic [27:0] d);
        cfg_we   = 1'b1;
        cfg_mask = m;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    // Collect up to n result beats (out_ready held high), bounded to 20 cycles
    task automatic collect(input int n, output logic [63:0] r0, output logic [63:0] r1,
                           output int got);
        got = 0;
        r0  = '0;
        r1  = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got < n; c++) begin
            if (out_valid) begin
                if (got == 0) r0 = out_data;
                else          r1 = out_data;
                got++;
            end
            tick();
        end
    endtask

    // Present one beat for a single edge, then collect its result
    task automatic send_one(input logic [63:0] x, input logic [1:0] m, input logic byp,
                            output logic [63:0] res, output int got);
        logic [63:0] dummy;
        in_valid  = 1'b1;
        in_data   = x;
        in_mask   = m;
        in_bypass = byp;
        tick();
        in_valid  = 1'b0;
        in_bypass = 1'b0;
        collect(1, res, dummy, got);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if (out_data !== 64'h0) begin
            bad++;
            $display("FAIL reset_out_data: got %h want 0", out_data);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_linear();
        int lat;
        logic [63:0] res;
        lat = 0;
        res = '0;
        cfg_write(2'd0, 4'd0, {12'h080, 16'h0040});
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {4{16'h0100}};
        in_mask   = 2'd0;
        tick();
        in_valid  = 1'b0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            if (out_valid) begin
                lat = c;
                res = out_data;
            end else begin
                tick();
            end
        end
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL linear_latency: got %0d want 3", lat);
        end
        total++;
        if (res !== {4{16'h00C0}}) begin
            bad++;
            $display("FAIL linear_value: got %h want %h", res, {4{16'h00C0}});
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL linear_single_beat: got %b want 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        logic [63:0] res;
        int got;
        cfg_write(2'd0, 4'd7, {12'h400, 16'h0000});
        cfg_write(2'd0, 4'd8, {12'h400, 16'h0000});
        send_one({16'h8000, 16'h7F00, 16'h8000, 16'h7F00}, 2'd0, 1'b0, res, got);
        total++;
        if (got != 1 || res !== {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF}) begin
            bad++;
            $display("FAIL saturation: got %h (beats %0d) want %h", res, got,
                     {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF});
        end
    endtask

    task automatic test_neg_bias();
        logic [63:0] res;
        int got;
        cfg_write(2'd1, 4'd0, {12'h000, 16'hFF00});
        send_one({16'h0FFF, 16'h0ABC, 16'h0100, 16'h0000}, 2'd1, 1'b0, res, got);
        total++;
        if (got != 1 || res !== {4{16'hFF00}}) begin
            bad++;
            $display("FAIL neg_bias: got %h (beats %0d) want %h", res, got, {4{16'hFF00}});
        end
    endtask

    task automatic test_bypass_mask();
        logic [63:0] res, r0, r1;
        int got;
        send_one({16'h0001, 16'h7F00, 16'h8000, 16'h1234}, 2'd0, 1'b1, res, got);
        total++;
        if (got != 1 || res !== {16'h0001, 16'h7F00, 16'h8000, 16'h1234}) begin
            bad++;
            $display("FAIL bypass: got %h want %h", res, {16'h0001, 16'h7F00, 16'h8000, 16'h1234});
        end
        cfg_write(2'd2, 4'd0, {12'h000, 16'h0100});
        cfg_write(2'd3, 4'd0, {12'h100, 16'h0200});
        in_valid = 1'b1;
        in_data  = {4{16'h0100}};
        in_mask  = 2'd2;
        tick();
        in_mask  = 2'd3;
        tick();
        in_valid = 1'b0;
        collect(2, r0, r1, got);
        total++;
        if (got != 2 || r0 !== {4{16'h0100}}) begin
            bad++;
            $display("FAIL mask2_beat: got %h (beats %0d) want %h", r0, got, {4{16'h0100}});
        end
        total++;
        if (got != 2 || r1 !== {4{16'h0300}}) begin
            bad++;
            $display("FAIL mask3_beat: got %h (beats %0d) want %h", r1, got, {4{16'h0300}});
        end
    endtask

    // Six beats through mask 0 / addr 0 (a=0.5, b=0.25) with a 4-cycle stall
    task automatic test_back_to_back();
        logic [63:0] xin [6];
        logic [63:0] exp [6];
        int sent, rcvd, stalls;
        logic acc, pop;
        for (int b = 0; b < 6; b++) begin
            for (int l = 0; l < 4; l++) begin
                logic [15:0] xv;
                xv = 16'(b * 256 + l * 32);
                xin[b][l*16 +: 16] = xv;
                exp[b][l*16 +: 16] = (xv >> 1) + 16'h0040;
            end
        end
        sent = 0;
        rcvd = 0;
        stalls = 0;
        in_mask = 2'd0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 8);
            in_valid  = (sent < 6);
            in_data   = (sent < 6) ? xin[sent] : 64'h0;
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_in_ready: cycle %0d got %b want 0", cyc, in_ready);
                end
            end
            if (out_valid) begin
                total++;
                if (rcvd >= 6) begin
                    bad++;
                    $display("FAIL extra_beat: cycle %0d got %h want none", cyc, out_data);
                end else if (out_data !== exp[rcvd]) begin
                    bad++;
                    $display("FAIL b2b_data: beat %0d cycle %0d got %h want %h",
                             rcvd, cyc, out_data, exp[rcvd]);
                end
            end
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            tick();
            if (acc) sent++;
            if (pop) rcvd++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (rcvd != 6) begin
            bad++;
            $display("FAIL b2b_count: got %0d want 6", rcvd);
        end
        total++;
        if (stalls != 4) begin
            bad++;
            $display("FAIL b2b_stall_cycles: got %0d want 4", stalls);
        end
    endtask

    task automatic test_hazard_reset();
        logic [63:0] r0, r1;
        int got;
        // Write addr 0 on the same edge that accepts a beat reading addr 0
        in_valid = 1'b1;
        in_data  = {4{16'h0100}};
        in_mask  = 2'd0;
        cfg_we   = 1'b1;
        cfg_mask = 2'd0;
        cfg_addr = 4'd0;
        cfg_data = {12'h000, 16'h0300};
        tick();
        cfg_we   = 1'b0;
        tick();
        in_valid = 1'b0;
        collect(2, r0, r1, got);
        total++;
        if (got != 2 || r0 !== {4{16'h00C0}}) begin
            bad++;
            $display("FAIL hazard_old: got %h (beats %0d) want %h", r0, got, {4{16'h00C0}});
        end
        total++;
        if (got != 2 || r1 !== {4{16'h0300}}) begin
            bad++;
            $display("FAIL hazard_new: got %h (beats %0d) want %h", r1, got, {4{16'h0300}});
        end
        // Two beats in flight, then reset
        in_valid = 1'b1;
        in_data  = {4{16'h0200}};
        tick();
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_valid: got %b want 0", out_valid);
        end
        total++;
        if (out_data !== 64'h0) begin
            bad++;
            $display("FAIL reset_mid_data: got %h want 0", out_data);
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_late_result: cycle %0d got %b want 0", c, out_valid);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mask   = '0;
        in_bypass = 1'b0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_mask  = '0;
        cfg_addr  = '0;
        cfg_data  = '0;
        #1;
        test_reset();
        test_linear();
        test_saturation();
        test_neg_bias();
        test_bypass_mask();
        test_back_to_back();
        test_hazard_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
